integer_dot_row_sequencer: RTL and testbench
============================================

INTEGER_DOT_ROW_SEQUENCER -- requirements
Module: integer_dot_row_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 16: element and result width.
REQ-002 SHALL have parameter WIDTH, default 30: elements per matrix row.
REQ-003 SHALL have parameter MULTS, default 3: dot-product lanes; LENGTH = WIDTH/MULTS beats per row.
REQ-004 SHALL have parameter ROWS, default 8: maximum rows per job.
REQ-005 SHALL have parameter TIMEOUT, default 64: maximum cycles to wait for a row result.
REQ-006 Ports, in order (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge.
- rstn  in  1  synchronous, active-low reset.
- start  in  1  job request, sampled in IDLE only.
- num_rows  in  $clog2(ROWS)+1  row count for the job, captured on accepted start.
- busy  out  1  high while a job runs.
- done  out  1  one-cycle pulse at job completion.
- error  out  1  sticky timeout flag, cleared by the next accepted start.
- mem_rd_en  out  1  operand read strobe, memory returns data next cycle.
- mem_row  out  $clog2(ROWS)  row index of the read.
- mem_beat  out  $clog2(LENGTH)  beat index of the read.
- mem_vec_a, mem_vec_b  in  BITS x MULTS  read data, valid one cycle after mem_rd_en.
- dp_in_valid  out  1  beat valid to the dot-product unit.
- dp_vector_a, dp_vector_b  out  BITS x MULTS  beat operands.
- dp_out_valid  in  1  dot-product result strobe.
- dp_c  in  BITS  dot-product result.
- res_valid  out  1  row result strobe.
- res_row  out  $clog2(ROWS)  row index of the result.
- res_data  out  BITS  row result.

Function
REQ-007 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-008 IDLE with start=1: capture min(num_rows, ROWS) and clear error.
- Count 0: go to DONE.
- Otherwise: go to ISSUE with row=0, beat=0.
REQ-009 ISSUE: mem_rd_en=1 every cycle, mem_row=row, mem_beat=beat, beat increments each cycle.
- After beat LENGTH-1, go to WAIT with beat=0.
- A row is always LENGTH contiguous cycles.
REQ-010 dp_in_valid SHALL equal mem_rd_en delayed one cycle; dp_vector_a/b SHALL pass mem_vec_a/b through combinationally.
REQ-011 WAIT: timer counts from 0.
- dp_out_valid=1: res_valid=1 on the next cycle, with res_row=row and res_data=dp_c. Then go to DONE if row is the last row; otherwise go to ISSUE with row+1.
- Timer reaching TIMEOUT with no dp_out_valid: set error=1, no res_valid, go to DONE.
REQ-012 No new row SHALL be issued until the previous row's result has been received (at most one row in flight).
REQ-013 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-014 busy SHALL be 1 in ISSUE, WAIT and DONE, and 0 in IDLE.
REQ-015 start while busy SHALL be ignored; it is neither queued nor used to update num_rows.
REQ-016 dp_out_valid outside WAIT SHALL be ignored, with no res_valid.
REQ-017 Latency: start accepted at edge T gives mem_rd_en high in cycles T+1 .. T+LENGTH and dp_in_valid high in cycles T+2 .. T+LENGTH+1.
REQ-018 mem_row, mem_beat, dp_vector_a/b and res_row/res_data are don't-care when their strobe is low; mem_row and mem_beat SHALL be 0 in IDLE.

Reset
REQ-019 rstn=0 at a clock edge SHALL force IDLE, with row, beat and timer = 0.
- Outputs busy, done, error, mem_rd_en, dp_in_valid, res_valid, res_row, res_data all 0.
REQ-020 Reset during ISSUE or WAIT SHALL abort the job with no done and no res_valid; a dp_out_valid arriving after reset SHALL be ignored.

Verification
REQ-021 Defaults, num_rows=2, model dot unit returning result 4 cycles after last beat:
- mem_rd_en high 10 cycles for row 0, then res_valid with res_row=0.
- Then 10 cycles for row 1, then res_valid with res_row=1.
- Then done pulse 1 cycle after last res_valid; error=0.
REQ-022 num_rows=0 -> done pulse 2 cycles after start, with no mem_rd_en and no res_valid.
REQ-023 num_rows=12 with ROWS=8 -> exactly 8 res_valid, res_row 0..7 in order.
REQ-024 Dot unit never responds -> error=1 and done pulse TIMEOUT+1 cycles after entering WAIT; next start clears error.
REQ-025 start pulsed during ISSUE, and dp_out_valid pulsed in IDLE -> no effect on row count or results.
REQ-026 rstn=0 at beat 5 of row 1 -> all outputs 0 next cycle, no done; a later start runs a clean job.

Source files
------------

// File: rtl/integer_dot_row_sequencer.sv
// Streams matrix rows beat-by-beat from operand memory into a dot-product unit
// and collects one result per row, keeping at most one row in flight.
module integer_dot_row_sequencer #(
   parameter int BITS    = 16,
   parameter int WIDTH   = 30,
   parameter int MULTS   = 3,
   parameter int ROWS    = 8,
   parameter int TIMEOUT = 64
) (
   input  logic                             clk,
   input  logic                             rstn,
   input  logic                             start,
   input  logic [$clog2(ROWS):0]            num_rows,
   output logic                             busy,
   output logic                             done,
   output logic                             error,
   output logic                             mem_rd_en,
   output logic [$clog2(ROWS)-1:0]          mem_row,
   output logic [$clog2(WIDTH/MULTS)-1:0]   mem_beat,
   input  logic [BITS*MULTS-1:0]            mem_vec_a,
   input  logic [BITS*MULTS-1:0]            mem_vec_b,
   output logic                             dp_in_valid,
   output logic [BITS*MULTS-1:0]            dp_vector_a,
   output logic [BITS*MULTS-1:0]            dp_vector_b,
   input  logic                             dp_out_valid,
   input  logic [BITS-1:0]                  dp_c,
   output logic                             res_valid,
   output logic [$clog2(ROWS)-1:0]          res_row,
   output logic [BITS-1:0]                  res_data
);

   localparam int LENGTH = WIDTH / MULTS;
   localparam int RW     = $clog2(ROWS);
   localparam int CW     = RW + 1;
   localparam int BW     = $clog2(LENGTH);
   localparam int TW     = $clog2(TIMEOUT + 1);

   localparam logic [CW-1:0] ROWS_C    = CW'(ROWS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(LENGTH - 1);
   localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   rows_reg, rows_next;
   logic [RW-1:0]   row_reg, row_next;
   logic [BW-1:0]   beat_reg, beat_next;
   logic [TW-1:0]   timer_reg, timer_next;
   logic [TW-1:0]   timer_inc;
   logic            error_reg, error_next;
   logic            done_reg;
   logic            dp_in_valid_reg;
   logic            res_valid_reg, res_valid_next;
   logic [RW-1:0]   res_row_reg, res_row_next;
   logic [BITS-1:0] res_data_reg, res_data_next;
   logic            last_row;

   // Operand data is forwarded lane by lane without registering.
   genvar gi;
   generate
      for (gi = 0; gi < MULTS; gi++) begin : g_lane
         assign dp_vector_a[gi*BITS +: BITS] = mem_vec_a[gi*BITS +: BITS];
         assign dp_vector_b[gi*BITS +: BITS] = mem_vec_b[gi*BITS +: BITS];
      end
   endgenerate

   assign last_row  = (({1'b0, row_reg} + CW'(1)) == rows_reg);
   assign timer_inc = timer_reg + TW'(1);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_reg       <= IDLE;
         rows_reg        <= '0;
         row_reg         <= '0;
         beat_reg        <= '0;
         timer_reg       <= '0;
         error_reg       <= 1'b0;
         done_reg        <= 1'b0;
         dp_in_valid_reg <= 1'b0;
         res_valid_reg   <= 1'b0;
         res_row_reg     <= '0;
         res_data_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         rows_reg        <= rows_next;
         row_reg         <= row_next;
         beat_reg        <= beat_next;
         timer_reg       <= timer_next;
         error_reg       <= error_next;
         done_reg        <= (state_reg == DONE);
         dp_in_valid_reg <= mem_rd_en;
         res_valid_reg   <= res_valid_next;
         res_row_reg     <= res_row_next;
         res_data_reg    <= res_data_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      rows_next      = rows_reg;
      row_next       = row_reg;
      beat_next      = beat_reg;
      timer_next     = timer_reg;
      error_next     = error_reg;
      res_valid_next = 1'b0;
      res_row_next   = res_row_reg;
      res_data_next  = res_data_reg;

      case (state_reg)
         IDLE: begin
            if (start) begin
               error_next = 1'b0;
               rows_next  = (num_rows > ROWS_C) ? ROWS_C : num_rows;
               row_next   = '0;
               beat_next  = '0;
               timer_next = '0;
               state_next = (num_rows == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (beat_reg == LAST_BEAT) begin
               beat_next  = '0;
               timer_next = '0;
               state_next = WAIT;
            end else begin
               beat_next = beat_reg + BW'(1);
            end
         end
         WAIT: begin
            // A result arriving on the final timer cycle still wins over the timeout.
            if (dp_out_valid) begin
               res_valid_next = 1'b1;
               res_row_next   = row_reg;
               res_data_next  = dp_c;
               if (last_row) begin
                  state_next = DONE;
               end else begin
                  row_next   = row_reg + RW'(1);
                  beat_next  = '0;
                  state_next = ISSUE;
               end
            end else if (timer_inc == TIMEOUT_C) begin
               error_next = 1'b1;
               state_next = DONE;
            end else begin
               timer_next = timer_inc;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy        = (state_reg != IDLE);
   assign done        = done_reg;
   assign error       = error_reg;
   assign mem_rd_en   = (state_reg == ISSUE);
   assign mem_row     = mem_rd_en ? row_reg : '0;
   assign mem_beat    = mem_rd_en ? beat_reg : '0;
   assign dp_in_valid = dp_in_valid_reg;
   assign res_valid   = res_valid_reg;
   assign res_row     = res_row_reg;
   assign res_data    = res_data_reg;

endmodule

// File: tb/tb_integer_dot_row_sequencer.sv
// Bench for integer_dot_row_sequencer: operand memory and dot-unit models,
// table of jobs, hand-written timeout / ignored-input / reset-abort sequences.
module tb_integer_dot_row_sequencer;

   localparam int BITS       = 16;
   localparam int MULTS      = 3;
   localparam int ROWS       = 8;
   localparam int LENGTH     = 10;
   localparam int TIMEOUT    = 64;
   localparam int RESP_DELAY = 4;

   logic                  clk = 1'b0;
   logic                  rstn;
   logic                  start;
   logic [3:0]            num_rows;
   logic                  busy, done, error;
   logic                  mem_rd_en;
   logic [2:0]            mem_row;
   logic [3:0]            mem_beat;
   logic [BITS*MULTS-1:0] mem_vec_a, mem_vec_b;
   logic                  dp_in_valid;
   logic [BITS*MULTS-1:0] dp_vector_a, dp_vector_b;
   logic                  dp_out_valid;
   logic [BITS-1:0]       dp_c;
   logic                  res_valid;
   logic [2:0]            res_row;
   logic [BITS-1:0]       res_data;

   always #5 clk = ~clk;

   integer_dot_row_sequencer dut (
      .clk          (clk),
      .rstn         (rstn),
      .start        (start),
      .num_rows     (num_rows),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .mem_rd_en    (mem_rd_en),
      .mem_row      (mem_row),
      .mem_beat     (mem_beat),
      .mem_vec_a    (mem_vec_a),
      .mem_vec_b    (mem_vec_b),
      .dp_in_valid  (dp_in_valid),
      .dp_vector_a  (dp_vector_a),
      .dp_vector_b  (dp_vector_b),
      .dp_out_valid (dp_out_valid),
      .dp_c         (dp_c),
      .res_valid    (res_valid),
      .res_row      (res_row),
      .res_data     (res_data)
   );

   function automatic logic [15:0] elem_a(int r, int b, int l);
      return 16'(r * 37 + b * 5 + l * 3 + 1);
   endfunction

   function automatic logic [15:0] elem_b(int r, int b, int l);
      return 16'(r * 11 + b * 7 + l * 13 + 2);
   endfunction

   function automatic logic [15:0] golden(int r);
      logic [15:0] s;
      s = '0;
      for (int b = 0; b < LENGTH; b++)
         for (int l = 0; l < MULTS; l++)
            s = s + 16'(elem_a(r, b, l) * elem_b(r, b, l));
      return s;
   endfunction

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Operand memory: data for the addressed beat one cycle after the read.
   always @(posedge clk) begin
      for (int l = 0; l < MULTS; l++) begin
         mem_vec_a[l*BITS +: BITS] <= mem_rd_en ? elem_a(int'(mem_row), int'(mem_beat), l) : 16'hDEAD;
         mem_vec_b[l*BITS +: BITS] <= mem_rd_en ? elem_b(int'(mem_row), int'(mem_beat), l) : 16'hDEAD;
      end
   end

   // Dot-product unit model: accumulates LENGTH beats, answers RESP_DELAY cycles later.
   bit          resp_en = 1'b1;
   int          inject_req = 0;
   int          inject_seen = 0;
   int          m_beats = 0;
   int          m_cnt = -1;
   logic [15:0] m_acc = '0;
   logic [15:0] m_result = '0;
   logic        m_fire;

   always @(negedge clk) begin
      m_fire = 1'b0;
      if (!rstn) begin
         m_beats = 0;
         m_acc   = '0;
         m_cnt   = -1;
      end else begin
         if (m_cnt == 0) m_fire = 1'b1;
         if (m_cnt >= 0) m_cnt = m_cnt - 1;
         if (dp_in_valid) begin
            for (int l = 0; l < MULTS; l++)
               m_acc = m_acc + 16'(dp_vector_a[l*BITS +: BITS] * dp_vector_b[l*BITS +: BITS]);
            m_beats = m_beats + 1;
            if (m_beats == LENGTH) begin
               m_result = m_acc;
               m_acc    = '0;
               m_beats  = 0;
               if (resp_en) m_cnt = RESP_DELAY - 1;
            end
         end
      end
      dp_out_valid = m_fire | (inject_req != inject_seen);
      dp_c         = m_fire ? m_result : 16'hBEEF;
      inject_seen  = inject_req;
   end

   typedef struct {
      int          row;
      logic [15:0] data;
   } exp_t;
   exp_t sb[$];

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (res_valid) begin
         if (sb.size() == 0) begin
            check("res_unexpected", int'(res_valid), 0);
         end else begin
            e = sb.pop_front();
            $display("res row=%0d data=%0d (expected row=%0d data=%0d)", res_row, res_data, e.row, e.data);
            check("res_row", int'(res_row), e.row);
            check("res_data", int'(res_data), int'(e.data));
         end
      end
   endtask

   int j_start, j_res, j_rd, j_din, j_first_rd, j_first_din, j_last_rd, j_last_res, j_done;
   bit j_err, j_err_after;

   // Called at a falling edge; returns after the cycle following the done pulse.
   task automatic run_job(input logic [3:0] n, input int n_push, input bit glitch);
      for (int p = 0; p < n_push; p++) sb.push_back('{row: p, data: golden(p)});
      j_res = 0; j_rd = 0; j_din = 0;
      j_first_rd = -1; j_first_din = -1; j_last_rd = -1; j_last_res = -1; j_done = -1;
      j_err = 1'b0;
      start = 1'b1;
      num_rows = n;
      j_start = cyc;
      tick();
      start = 1'b0;
      j_err_after = error;
      for (int k = 1; k <= 3000 && j_done < 0; k++) begin
         if (mem_rd_en) begin
            j_rd++;
            if (j_first_rd < 0) j_first_rd = cyc;
            j_last_rd = cyc;
         end
         if (dp_in_valid) begin
            j_din++;
            if (j_first_din < 0) j_first_din = cyc;
         end
         if (res_valid) begin
            j_res++;
            j_last_res = cyc;
         end
         if (done) begin
            j_done = cyc;
            j_err  = error;
         end
         if (glitch && k == 3) begin
            start = 1'b1;
            num_rows = 4'd7;
         end
         if (glitch && k == 4) start = 1'b0;
         if (glitch && k == 5) inject_req++;
         if (j_done < 0) tick();
      end
      if (j_done < 0) check("done_seen", int'(done), 1);
      $display("job n=%0d: rd=%0d din=%0d res=%0d done@+%0d err=%0d", n, j_rd, j_din, j_res, j_done - j_start, j_err);
      tick();
      check("done_width", int'(done), 0);
      check("idle_after_done", int'(busy), 0);
   endtask

   typedef struct {
      logic [3:0] n;
      int         exp_res;
      int         exp_rd;
      logic       exp_err;
      int         exp_lat;
   } vec_t;

   vec_t tbl[6];
   int   cnt_done, cnt_res;
   bit   found;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // {num_rows, results, read cycles, error, done latency (after last result, or after start if none)}
      tbl[0] = '{4'd2,  2, 20, 1'b0, 1};
      tbl[1] = '{4'd0,  0,  0, 1'b0, 2};
      tbl[2] = '{4'd12, 8, 80, 1'b0, 1};
      tbl[3] = '{4'd1,  1, 10, 1'b0, 1};
      tbl[4] = '{4'd5,  5, 50, 1'b0, 1};
      tbl[5] = '{4'd15, 8, 80, 1'b0, 1};

      rstn = 1'b0;
      start = 1'b0;
      num_rows = '0;
      repeat (3) tick();
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_error", int'(error), 0);
      check("rst_rd_en", int'(mem_rd_en), 0);
      check("rst_dp_in_valid", int'(dp_in_valid), 0);
      check("rst_res_valid", int'(res_valid), 0);
      check("rst_res_row_data", int'({res_row, res_data}), 0);
      check("rst_mem_addr", int'({mem_row, mem_beat}), 0);
      rstn = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         run_job(tbl[i].n, tbl[i].exp_res, 1'b0);
         check($sformatf("v%0d_res_count", i), j_res, tbl[i].exp_res);
         check($sformatf("v%0d_rd_cycles", i), j_rd, tbl[i].exp_rd);
         check($sformatf("v%0d_din_cycles", i), j_din, tbl[i].exp_rd);
         check($sformatf("v%0d_error", i), int'(j_err), int'(tbl[i].exp_err));
         check($sformatf("v%0d_err_after_start", i), int'(j_err_after), 0);
         if (tbl[i].exp_res > 0)
            check($sformatf("v%0d_done_lat", i), j_done - j_last_res, tbl[i].exp_lat);
         else
            check($sformatf("v%0d_done_lat", i), j_done - j_start, tbl[i].exp_lat);
         if (tbl[i].exp_rd > 0) begin
            check($sformatf("v%0d_first_rd", i), j_first_rd - j_start, 1);
            check($sformatf("v%0d_first_din", i), j_first_din - j_start, 2);
         end
         check($sformatf("v%0d_sb_drained", i), sb.size(), 0);
      end

      // Dot unit silent: timeout after TIMEOUT cycles in WAIT, then the next start clears error.
      resp_en = 1'b0;
      run_job(4'd1, 0, 1'b0);
      check("to_error", int'(j_err), 1);
      check("to_res_count", j_res, 0);
      check("to_rd_cycles", j_rd, LENGTH);
      check("to_done_lat", j_done - (j_last_rd + 1), TIMEOUT + 1);
      check("to_error_sticky", int'(error), 1);
      resp_en = 1'b1;
      tick();
      run_job(4'd1, 1, 1'b0);
      check("to_clear_on_start", int'(j_err_after), 0);
      check("to_next_error", int'(j_err), 0);
      check("to_next_res", j_res, 1);

      // Result strobe while idle, then start and result strobes during ISSUE.
      inject_req++;
      cnt_res = 0;
      repeat (3) begin
         tick();
         if (res_valid) cnt_res++;
      end
      check("idle_dp_ignored", cnt_res, 0);
      run_job(4'd2, 2, 1'b1);
      check("glitch_res_count", j_res, 2);
      check("glitch_rd_cycles", j_rd, 2 * LENGTH);
      check("glitch_sb_drained", sb.size(), 0);
      repeat (4) tick();
      check("glitch_not_queued", int'(busy), 0);

      // Reset at beat 5 of row 1 aborts the job.
      sb.push_back('{row: 0, data: golden(0)});
      start = 1'b1;
      num_rows = 4'd3;
      tick();
      start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         if (mem_rd_en && mem_row == 3'd1 && mem_beat == 4'd5) found = 1'b1;
         else tick();
      end
      check("abort_point_found", int'(found), 1);
      rstn = 1'b0;
      tick();
      $display("abort: busy=%0d done=%0d rd_en=%0d din=%0d res=%0d res_data=%0d", busy, done, mem_rd_en, dp_in_valid, res_valid, res_data);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_error", int'(error), 0);
      check("abort_strobes", int'({mem_rd_en, dp_in_valid, res_valid}), 0);
      check("abort_res_row_data", int'({res_row, res_data}), 0);
      check("abort_mem_addr", int'({mem_row, mem_beat}), 0);
      rstn = 1'b1;
      inject_req++;
      cnt_done = 0;
      cnt_res = 0;
      repeat (100) begin
         tick();
         if (done) cnt_done++;
         if (res_valid) cnt_res++;
      end
      check("abort_no_done", cnt_done, 0);
      check("abort_no_res", cnt_res, 0);
      check("abort_sb_drained", sb.size(), 0);
      run_job(4'd2, 2, 1'b0);
      check("post_abort_res", j_res, 2);
      check("post_abort_error", int'(j_err), 0);
      check("post_abort_done_lat", j_done - j_last_res, 1);
      check("post_abort_sb_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
